// File: rtl/access_pkg.sv
// Shared types and helpers for the terminal access arbiter.
package access_pkg;

  // Per-terminal tenure state.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } slot_state_e;

  // Default sizes of the standard two-user, two-terminal build.
  localparam int N_USERS_DEF = 2;
  localparam int N_TERM_DEF  = 2;

  // Index width for n items, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int TERM_W = width_of(N_TERM_DEF);
  localparam int UID_W  = width_of(N_USERS_DEF);

  // A request may reach arbitration only if it names a real function that
  // its authentication level covers, on a terminal that exists.
  function automatic logic func_permitted(input int unsigned level,
                                          input int unsigned func,
                                          input int unsigned term,
                                          input int unsigned n_term = N_TERM_DEF);
    return (func != 0) && (func <= level) && (term < n_term);
  endfunction

endpackage

// File: rtl/terminal_slot.sv
// One output terminal: picks a winner among its candidates, holds a timed
// tenure, and handles release, expiry and preemption by a higher level.
//
// state | meaning
// IDLE  | terminal free, grants the best candidate on the next edge
// BUSY  | terminal owned, counter runs down the remaining tenure
module terminal_slot
  import access_pkg::*;
#(
  parameter int N_USERS  = 2,
  parameter int LEVEL_W  = 3,
  parameter int FUNC_W   = 3,
  parameter int HOLD_CYC = 8,
  parameter int U_W      = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_USERS-1:0]          cand,
  input  logic [N_USERS*LEVEL_W-1:0]  req_level,
  input  logic [N_USERS*FUNC_W-1:0]   req_func,
  input  logic [N_USERS-1:0]          rel,
  output logic [N_USERS-1:0]          slot_grant,
  output logic [N_USERS-1:0]          slot_revoke,
  output logic                        slot_valid,
  output logic [FUNC_W-1:0]           slot_func,
  output logic [U_W-1:0]              slot_owner
);

  localparam int CNT_W = $clog2(HOLD_CYC + 1);

  slot_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [U_W-1:0]       owner_q, owner_d;
  logic [LEVEL_W-1:0]   lvl_q, lvl_d;
  logic [FUNC_W-1:0]    func_q, func_d;
  logic [U_W-1:0]       rr_q, rr_d;
  logic [N_USERS-1:0]   grant_q, grant_d;
  logic [N_USERS-1:0]   revoke_q, revoke_d;

  logic [LEVEL_W-1:0]   lvl_a  [N_USERS];
  logic [FUNC_W-1:0]    func_a [N_USERS];

  logic [N_USERS-1:0]   cand_eff;
  logic [U_W-1:0]       scan_u;
  logic                 best_found;
  logic [U_W-1:0]       best_idx;
  logic [LEVEL_W-1:0]   best_lvl;
  logic [U_W-1:0]       rr_next;
  logic                 preempt;

  for (genvar u = 0; u < N_USERS; u++) begin : g_unpack
    assign lvl_a[u]  = req_level[u*LEVEL_W +: LEVEL_W];
    assign func_a[u] = req_func[u*FUNC_W +: FUNC_W];
  end

  // Winner select: highest level, ties to the first user at or after rr_q.
  always_comb begin
    cand_eff   = cand;
    scan_u     = '0;
    best_found = 1'b0;
    best_idx   = '0;
    best_lvl   = '0;
    if (state_q == BUSY) begin
      cand_eff[owner_q] = 1'b0;
    end
    for (int i = 0; i < N_USERS; i++) begin
      scan_u = U_W'((int'(rr_q) + i) % N_USERS);
      // Strict compare keeps the earliest tied user in scan order.
      if (cand_eff[scan_u] && (!best_found || (lvl_a[scan_u] > best_lvl))) begin
        best_found = 1'b1;
        best_idx   = scan_u;
        best_lvl   = lvl_a[scan_u];
      end
    end
    rr_next = (best_idx == U_W'(N_USERS - 1)) ? '0 : best_idx + 1'b1;
    preempt = (state_q == BUSY) && best_found && (best_lvl > lvl_q);
  end

  // Next-state: grant from IDLE, preempt/release/expire from BUSY.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    lvl_d    = lvl_q;
    func_d   = func_q;
    rr_d     = rr_q;
    grant_d  = '0;
    revoke_d = '0;
    case (state_q)
      IDLE: begin
        if (best_found) begin
          state_d           = BUSY;
          cnt_d             = CNT_W'(HOLD_CYC);
          owner_d           = best_idx;
          lvl_d             = best_lvl;
          func_d            = func_a[best_idx];
          rr_d              = rr_next;
          grant_d[best_idx] = 1'b1;
        end
      end
      BUSY: begin
        // Preemption takes precedence over both release and expiry.
        if (preempt) begin
          cnt_d             = CNT_W'(HOLD_CYC);
          owner_d           = best_idx;
          lvl_d             = best_lvl;
          func_d            = func_a[best_idx];
          rr_d              = rr_next;
          grant_d[best_idx] = 1'b1;
          revoke_d[owner_q] = 1'b1;
        end else if (rel[owner_q] || (cnt_q <= CNT_W'(1))) begin
          // Owner/func/level clear so the outputs read 0 while free.
          state_d = IDLE;
          cnt_d   = '0;
          owner_d = '0;
          lvl_d   = '0;
          func_d  = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        owner_d = '0;
        lvl_d   = '0;
        func_d  = '0;
      end
    endcase
  end

  // Slot state and registered outputs; reset drops ownership at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      owner_q  <= '0;
      lvl_q    <= '0;
      func_q   <= '0;
      rr_q     <= '0;
      grant_q  <= '0;
      revoke_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      lvl_q    <= lvl_d;
      func_q   <= func_d;
      rr_q     <= rr_d;
      grant_q  <= grant_d;
      revoke_q <= revoke_d;
    end
  end

  assign slot_grant  = grant_q;
  assign slot_revoke = revoke_q;
  assign slot_valid  = (state_q == BUSY);
  assign slot_func   = func_q;
  assign slot_owner  = owner_q;

endmodule

// File: rtl/terminal_access_arbiter.sv
// Top level: screens each user's request for permission, denies the rest,
// and hands permitted requests to one terminal_slot per output terminal.
module terminal_access_arbiter
  import access_pkg::*;
#(
  parameter int N_USERS  = 2,
  parameter int N_TERM   = 2,
  parameter int LEVEL_W  = 3,
  parameter int FUNC_W   = 3,
  parameter int HOLD_CYC = 8,
  // Per-instance index widths (the package values cover the default build).
  localparam int T_W = width_of(N_TERM),
  localparam int U_W = width_of(N_USERS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_USERS-1:0]         req_valid,
  input  logic [N_USERS*LEVEL_W-1:0] req_level,
  input  logic [N_USERS*FUNC_W-1:0]  req_func,
  input  logic [N_USERS*T_W-1:0]     req_term,
  input  logic [N_USERS-1:0]         rel,
  output logic [N_USERS-1:0]         grant,
  output logic [N_USERS-1:0]         deny,
  output logic [N_USERS-1:0]         revoke,
  output logic [N_TERM-1:0]          term_valid,
  output logic [N_TERM*FUNC_W-1:0]   term_func,
  output logic [N_TERM*U_W-1:0]      term_owner
);

  logic [LEVEL_W-1:0]  lvl_a  [N_USERS];
  logic [FUNC_W-1:0]   func_a [N_USERS];
  logic [T_W-1:0]      term_a [N_USERS];
  logic [N_USERS-1:0]  permitted;

  logic [N_USERS-1:0]  deny_q, deny_d;
  logic [N_USERS-1:0]  cand        [N_TERM];
  logic [N_USERS-1:0]  slot_grant  [N_TERM];
  logic [N_USERS-1:0]  slot_revoke [N_TERM];
  logic [N_USERS-1:0]  grant_or;
  logic [N_USERS-1:0]  revoke_or;

  for (genvar u = 0; u < N_USERS; u++) begin : g_user
    assign lvl_a[u]     = req_level[u*LEVEL_W +: LEVEL_W];
    assign func_a[u]    = req_func[u*FUNC_W +: FUNC_W];
    assign term_a[u]    = req_term[u*T_W +: T_W];
    assign permitted[u] = func_permitted(32'(lvl_a[u]), 32'(func_a[u]),
                                         32'(term_a[u]), 32'(N_TERM));
  end

  // Rejected requests are flagged every cycle they are presented.
  always_comb begin
    deny_d = req_valid & ~permitted;
  end

  // Registered deny pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deny_q <= '0;
    end else begin
      deny_q <= deny_d;
    end
  end

  for (genvar t = 0; t < N_TERM; t++) begin : g_slot
    for (genvar u = 0; u < N_USERS; u++) begin : g_cand
      assign cand[t][u] = req_valid[u] & permitted[u] & (term_a[u] == T_W'(t));
    end

    terminal_slot #(
      .N_USERS  (N_USERS),
      .LEVEL_W  (LEVEL_W),
      .FUNC_W   (FUNC_W),
      .HOLD_CYC (HOLD_CYC),
      .U_W      (U_W)
    ) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .cand        (cand[t]),
      .req_level   (req_level),
      .req_func    (req_func),
      .rel         (rel),
      .slot_grant  (slot_grant[t]),
      .slot_revoke (slot_revoke[t]),
      .slot_valid  (term_valid[t]),
      .slot_func   (term_func[t*FUNC_W +: FUNC_W]),
      .slot_owner  (term_owner[t*U_W +: U_W])
    );
  end

  // Merge per-terminal pulses; a user targets one terminal, so at most one
  // slot can grant or revoke it in any cycle.
  always_comb begin
    grant_or  = '0;
    revoke_or = '0;
    for (int t = 0; t < N_TERM; t++) begin
      grant_or  = grant_or  | slot_grant[t];
      revoke_or = revoke_or | slot_revoke[t];
    end
  end

  assign grant  = grant_or;
  assign revoke = revoke_or;
  assign deny   = deny_q;

endmodule

// File: tb/tb_terminal_access_arbiter.sv
// Directed bench with a rule-level reference model compared every cycle.
module tb_terminal_access_arbiter;

  localparam int NU = 2;
  localparam int NT = 2;
  localparam int LW = 3;
  localparam int FW = 3;
  localparam int HC = 8;
  localparam int TW = 1;
  localparam int UW = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NU-1:0]     req_valid = '0;
  logic [NU*LW-1:0]  req_level = '0;
  logic [NU*FW-1:0]  req_func = '0;
  logic [NU*TW-1:0]  req_term = '0;
  logic [NU-1:0]     rel = '0;
  logic [NU-1:0]     grant, deny, revoke;
  logic [NT-1:0]     term_valid;
  logic [NT*FW-1:0]  term_func;
  logic [NT*UW-1:0]  term_owner;

  int n_chk = 0;
  int n_err = 0;

  terminal_access_arbiter #(
    .N_USERS(NU), .N_TERM(NT), .LEVEL_W(LW), .FUNC_W(FW), .HOLD_CYC(HC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_level(req_level),
    .req_func(req_func), .req_term(req_term), .rel(rel), .grant(grant),
    .deny(deny), .revoke(revoke), .term_valid(term_valid),
    .term_func(term_func), .term_owner(term_owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int u, input bit v, input int l, input int f, input int t);
    req_valid[u]           = v;
    req_level[u*LW +: LW]  = LW'(l);
    req_func[u*FW +: FW]   = FW'(f);
    req_term[u*TW +: TW]   = TW'(t);
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_level = '0;
    req_func  = '0;
    req_term  = '0;
    rel       = '0;
  endtask

  // ---------------- reference model (rule level) ----------------
  int m_own [NT];
  int m_lvl [NT];
  int m_func[NT];
  int m_left[NT];
  int m_rr  [NT];
  int mu_l[NU], mu_f[NU], mu_t[NU];
  bit mu_ok[NU];
  int best, bestl, cu;

  logic [NU-1:0]    exp_grant = '0, exp_deny = '0, exp_revoke = '0;
  logic [NT-1:0]    exp_valid = '0;
  logic [NT*FW-1:0] exp_func = '0;
  logic [NT*UW-1:0] exp_owner = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NT; t++) begin
        m_own[t] = -1; m_lvl[t] = 0; m_func[t] = 0; m_left[t] = 0; m_rr[t] = 0;
      end
      exp_grant = '0; exp_deny = '0; exp_revoke = '0;
      exp_valid = '0; exp_func = '0; exp_owner = '0;
    end else begin
      exp_grant = '0; exp_deny = '0; exp_revoke = '0;
      for (int u = 0; u < NU; u++) begin
        mu_l[u]  = int'(req_level[u*LW +: LW]);
        mu_f[u]  = int'(req_func[u*FW +: FW]);
        mu_t[u]  = int'(req_term[u*TW +: TW]);
        mu_ok[u] = (mu_f[u] != 0) && (mu_f[u] <= mu_l[u]) && (mu_t[u] < NT);
        if (req_valid[u] && !mu_ok[u]) exp_deny[u] = 1'b1;
      end
      for (int t = 0; t < NT; t++) begin
        best = -1; bestl = -1;
        for (int k = 0; k < NU; k++) begin
          cu = (m_rr[t] + k) % NU;
          if (req_valid[cu] && mu_ok[cu] && mu_t[cu] == t && cu != m_own[t] && mu_l[cu] > bestl) begin
            best = cu; bestl = mu_l[cu];
          end
        end
        if (best >= 0 && (m_own[t] < 0 || bestl > m_lvl[t])) begin
          if (m_own[t] >= 0) exp_revoke[m_own[t]] = 1'b1;
          m_own[t] = best; m_lvl[t] = bestl; m_func[t] = mu_f[best];
          m_left[t] = HC; m_rr[t] = (best + 1) % NU;
          exp_grant[best] = 1'b1;
        end else if (m_own[t] >= 0) begin
          if (rel[m_own[t]] || m_left[t] == 1) m_own[t] = -1;
          else m_left[t] = m_left[t] - 1;
        end
      end
      for (int t = 0; t < NT; t++) begin
        exp_valid[t]          = (m_own[t] >= 0);
        exp_func[t*FW +: FW]  = (m_own[t] >= 0) ? FW'(m_func[t]) : '0;
        exp_owner[t*UW +: UW] = (m_own[t] >= 0) ? UW'(m_own[t]) : '0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("grant", 32'(grant), 32'(exp_grant));
    chk("deny", 32'(deny), 32'(exp_deny));
    chk("revoke", 32'(revoke), 32'(exp_revoke));
    chk("term_valid", 32'(term_valid), 32'(exp_valid));
    chk("term_func", 32'(term_func), 32'(exp_func));
    chk("term_owner", 32'(term_owner), 32'(exp_owner));
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int cnt;
    int seq[3];
    int ng;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({grant, deny, revoke, term_valid, term_func, term_owner}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Deny: level 2 cannot run function 5.
    set_req(0, 1, 2, 5, 0);
    @(negedge clk);
    chk("deny_first", 32'(deny), 32'h1);
    chk("deny_no_grant", 32'(grant), 32'h0);
    @(negedge clk);
    chk("deny_held", 32'(deny), 32'h1);
    chk("deny_no_valid", 32'(term_valid), 32'h0);
    clear_reqs();
    @(negedge clk);
    chk("deny_cleared", 32'(deny), 32'h0);

    // Single grant on terminal 1, then natural expiry after 8 cycles.
    set_req(0, 1, 5, 3, 1);
    @(negedge clk);
    chk("single_grant", 32'(grant), 32'h1);
    chk("single_valid", 32'(term_valid), 32'h2);
    chk("single_func", 32'(term_func[5:3]), 32'd3);
    chk("single_owner", 32'(term_owner[1]), 32'd0);
    clear_reqs();
    cnt = 0;
    while (term_valid[1] && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    chk("single_tenure_len", 32'(cnt), 32'd8);
    repeat (2) @(negedge clk);

    // Level priority: level 6 beats level 3; loser granted after a gap.
    set_req(0, 1, 3, 2, 0);
    set_req(1, 1, 6, 2, 0);
    @(negedge clk);
    chk("prio_grant", 32'(grant), 32'h2);
    set_req(1, 0, 0, 0, 0);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!grant[0] && cnt < 30);
    chk("prio_loser_delay", 32'(cnt), 32'd9);
    chk("prio_loser_owner", 32'(term_owner[0]), 32'd0);
    clear_reqs();
    repeat (10) @(negedge clk);

    // Round-robin from a fresh pointer: equal levels alternate 0,1,0.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1, 4, 2, 0);
    set_req(1, 1, 4, 2, 0);
    ng = 0; cnt = 0;
    while (ng < 3 && cnt < 60) begin
      @(negedge clk);
      cnt++;
      if (grant != 0) begin
        seq[ng] = grant[1] ? 1 : 0;
        ng++;
      end
    end
    chk("rr_count", 32'(ng), 32'd3);
    chk("rr_seq", 32'({seq[0][3:0], seq[1][3:0], seq[2][3:0]}), 32'h010);
    clear_reqs();
    repeat (10) @(negedge clk);

    // Preemption by level 7 at tenure cycle 3, counter reloads.
    set_req(0, 1, 3, 3, 0);
    @(negedge clk);
    chk("pre_first_grant", 32'(grant), 32'h1);
    set_req(0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    set_req(1, 1, 7, 4, 0);
    @(negedge clk);
    chk("pre_revoke", 32'(revoke), 32'h1);
    chk("pre_grant", 32'(grant), 32'h2);
    chk("pre_owner", 32'(term_owner[0]), 32'd1);
    chk("pre_func", 32'(term_func[2:0]), 32'd4);
    set_req(1, 0, 0, 0, 0);
    cnt = 0;
    while (term_valid[0] && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    chk("pre_reload_len", 32'(cnt), 32'd8);
    repeat (2) @(negedge clk);

    // Equal level never preempts.
    set_req(0, 1, 3, 2, 0);
    @(negedge clk);
    chk("eq_first_grant", 32'(grant), 32'h1);
    set_req(0, 0, 0, 0, 0);
    set_req(1, 1, 3, 1, 0);
    repeat (3) begin
      @(negedge clk);
      chk("eq_no_revoke", 32'(revoke), 32'h0);
      chk("eq_owner_kept", 32'(term_owner[0]), 32'd0);
    end
    clear_reqs();
    repeat (12) @(negedge clk);

    // Release: non-owner rel ignored, owner rel drops term_valid next cycle.
    set_req(0, 1, 5, 1, 1);
    @(negedge clk);
    chk("rel_grant", 32'(grant), 32'h1);
    clear_reqs();
    rel[1] = 1'b1;
    @(negedge clk);
    chk("rel_nonowner_ignored", 32'(term_valid[1]), 32'd1);
    rel[1] = 1'b0;
    rel[0] = 1'b1;
    @(negedge clk);
    chk("rel_owner_drop", 32'(term_valid[1]), 32'd0);
    rel[0] = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-tenure.
    set_req(0, 1, 5, 5, 0);
    @(negedge clk);
    chk("rst_pre_valid", 32'(term_valid), 32'h1);
    clear_reqs();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(term_valid), 32'h0);
    chk("rst_async_func", 32'(term_func), 32'h0);
    chk("rst_async_revoke", 32'(revoke), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/terminal_access_arbiter.md
# terminal_access_arbiter

Clocked, parametrised successor to the two-user combinational access-control path. It takes N users' requests, each carrying an authentication level, a function code and a target terminal. For every output terminal (LED bar, LED matrix, 7-seg, …) it checks permission, arbitrates by level with round-robin tie-break, and holds a timed tenure. The block sits between the user-input decoders and the per-terminal output decoders; each decoder consumes `term_func` for its terminal.

## Interface
- `N_USERS`, 2: number of requesting users.
- `N_TERM`, 2: number of output terminals.
- `LEVEL_W`, 3: authentication level width; level 0 means no rights.
- `FUNC_W`, 3: function code width; code 0 means "no function".
- `HOLD_CYC`, 8: tenure length in cycles, ≥1.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  N_USERS  request asserted; held by the user until `grant` or `deny`.
- `req_level`  in  N_USERS*LEVEL_W  per-user authentication level.
- `req_func`  in  N_USERS*FUNC_W  per-user function code.
- `req_term`  in  N_USERS*TERM_W  per-user target terminal; TERM_W = max(1, $clog2(N_TERM)).
- `rel`  in  N_USERS  owner requests early release of its terminal.
- `grant`  out  N_USERS  1-cycle pulse: user became owner of `req_term`.
- `deny`  out  N_USERS  1-cycle pulse: request rejected.
- `revoke`  out  N_USERS  1-cycle pulse: user lost its terminal to preemption.
- `term_valid`  out  N_TERM  terminal currently owned.
- `term_func`  out  N_TERM*FUNC_W  owner's function code; 0 when not valid.
- `term_owner`  out  N_TERM*UID_W  owner index, UID_W = max(1, $clog2(N_USERS)); 0 when not valid.

## Operation
- Permission rule: a request is permitted iff `func != 0`, `func <= level` and `req_term < N_TERM`.
- Non-permitted valid requests produce `deny` on every cycle they are sampled. They never reach arbitration.
- Per-terminal FSM has two states, IDLE and BUSY.
- Candidates for terminal t are users with valid, permitted requests whose `req_term == t`. The current owner of t is excluded.
- IDLE with ≥1 candidate: the winner is the highest level. Ties go to the first tied user at or after `rr_ptr[t]`, scanning upward with wrap.
- On a win: go to BUSY, latch owner/level/func, load counter = HOLD_CYC, pulse `grant`, set `rr_ptr[t]` = winner+1 mod N_USERS.
- Losers get neither `grant` nor `deny` and keep requesting.
- BUSY: the counter decrements each cycle. At counter==1 with no preemptor, the terminal returns to IDLE.
- An owner `rel` pulse also returns the terminal to IDLE at the next edge.
- Preemption in BUSY: a candidate with level strictly greater than the latched owner level replaces the owner. The counter reloads, the new user gets `grant` and the old owner gets `revoke` in the same cycle.
- Equal-level candidates never preempt.
- Simultaneous events on one terminal: preemption beats expiry and beats `rel`.
- A user receives at most one grant per cycle. If it wins on several terminals (impossible with a single `req_term`), the lowest t wins.

## Timing
- All outputs are registered. Grant latency is 1 cycle: a request sampled at edge k gives `grant`/`term_valid` after edge k.
- Tenure: `term_valid` stays high for exactly HOLD_CYC cycles absent release or preemption.
- There is at least one IDLE cycle between consecutive non-preemptive tenures on a terminal.
- `rel` takes effect at the next edge; `term_valid` drops 1 cycle after `rel`. `rel` from a non-owner is ignored.
- Reset value: every output is 0, all FSMs are IDLE, all `rr_ptr` are 0, counters are 0.
- Reset assertion mid-tenure clears `term_valid` immediately (asynchronously). No `revoke` is issued.

## Structure
- Package `access_pkg` holds:
  - state enum `slot_state_e` {IDLE, BUSY};
  - function `func_permitted(level, func, term)`;
  - localparams TERM_W and UID_W.
- Sub-module `terminal_slot` owns one terminal: FSM, counter, rr pointer, winner select. It is instantiated N_TERM times in a generate loop.
- The top level computes permission and `deny`, and ORs the per-slot `grant`/`revoke` vectors.

## Test plan
- Deny: user0 level=2, func=5 valid → `deny[0]` the next cycle; no `grant`, `term_valid` stays 0.
- Single grant and expiry: user0 level=5, func=3, term=1 → after 1 cycle `term_valid[1]`=1, `term_func`=3, owner=0, `grant[0]` pulse; `term_valid[1]` falls after exactly 8 cycles.
- Level priority: user0 level=3 and user1 level=6 both target term 0 with func=2 → user1 granted, user0 keeps waiting and is granted 1 cycle after user1's tenure ends.
- Round-robin: two users with equal level=4 request term 0 continuously → grants alternate 0, 1, 0 across tenures.
- Preemption: user0 (level 3) owns term 0; at tenure cycle 3 user1 (level 7) requests → `revoke[0]` and `grant[1]` in the same cycle, counter reloaded to 8. A level-3 user1 request does not preempt.
- Release and reset: `rel[0]` during tenure → `term_valid` low 1 cycle later. `rst_n` low mid-tenure → all outputs 0 immediately.
